tanh_backward_seq: RTL
======================

TANH_BACKWARD_SEQ -- requirements
Module: tanh_backward_seq

Interface
REQ-001 SHALL have parameter HID_DIM, default 24, the matrix side; element count N = HID_DIM*HID_DIM.
REQ-002 SHALL have parameter N_LEN, default 16, the signed gradient element width.
REQ-003 SHALL have parameter N_LEN_W, default 16, the signed stored-activation element width.
REQ-004 SHALL have parameter F_LEN, default 10, the fraction bits shared by all elements (ONE = 2^F_LEN = 1024).
REQ-005 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port load  in  1  capture y_in into the activation store.
REQ-008 SHALL have port y_in  in  N*N_LEN_W  tanh forward output y, element i at bits [i*N_LEN_W +: N_LEN_W].
REQ-009 SHALL have port run  in  1  start a backward pass.
REQ-010 SHALL have port dy  in  N*N_LEN  upstream gradient, same element packing.
REQ-011 SHALL have port busy  out  1  high while a pass is in progress.
REQ-012 SHALL have port valid  out  1  one-cycle pulse when dx is complete.
REQ-013 SHALL have port dx  out  N*N_LEN  registered result gradient, same element packing.

Function
REQ-014 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-015 In IDLE with load=1, SHALL copy y_in into the y store at that edge; load outside IDLE SHALL be ignored.
REQ-016 In IDLE with run=1, SHALL copy dy into the dy store, clear index idx to 0, and enter COMPUTE.
REQ-017 With load and run both high in IDLE, SHALL compute with the y_in value sampled on that same edge.
REQ-018 run outside IDLE SHALL be ignored, with no restart and no effect on dx.
REQ-019 In COMPUTE, SHALL process exactly one element per cycle: dx element idx is written and idx increments.
REQ-020 After element N-1 is written, SHALL enter DONE; in DONE valid=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 Latency: with run sampled at edge 0, valid SHALL be high in the cycle after edge N+1; busy SHALL be high from edge 1 through the end of DONE.
REQ-022 Per element, p = (y*y) >>> F_LEN, computed in 2*N_LEN_W bits with an arithmetic (floor) shift.
REQ-023 Per element, s = ONE - p, held signed at 2*N_LEN_W+1 bits with no truncation.
REQ-024 Per element, r = (dy*s) >>> F_LEN, at full product width with a floor shift.
REQ-025 Per element, dx = r saturated to the signed N_LEN range [-2^(N_LEN-1), 2^(N_LEN-1)-1].
REQ-026 dx elements not yet rewritten during a pass SHALL hold their previous values; dx SHALL stay stable between passes.
REQ-027 The y store SHALL persist across passes; several runs after one load SHALL reuse the same y.

Reset
REQ-028 When rst=1 at a clock edge, SHALL set the state to IDLE, busy=0, valid=0, idx=0, dx=0, y store=0, and dy store=0, taking priority over load and run.
REQ-029 rst asserted mid-COMPUTE or in DONE SHALL abort the pass with no valid pulse, and dx SHALL read all zero afterwards.

Verification (F_LEN=10, N_LEN=N_LEN_W=16; all elements equal unless stated)
REQ-030 Zero activation: load y=0, run dy=1024 -> valid in cycle after edge N+1, every dx=1024, busy=0 afterwards.
REQ-031 Nominal and sign: y=512, dy=1024 -> dx=768; y=-512, dy=-2048 -> dx=-1536; y=1024, dy=5000 -> dx=0.
REQ-032 Floor rounding: y=512, dy=-1 -> dx=-1; y=1, dy=1 -> dx=1.
REQ-033 Saturation: y=32767, dy=32767 -> dx=-32768; y=32767, dy=-32767 -> dx=32767.
REQ-034 Control corners: run pulsed again mid-COMPUTE -> ignored, exactly one valid pulse; load and run on the same edge -> new y used; load during COMPUTE -> next pass still uses the old y.
REQ-035 Reset mid-pass: rst at idx=N/2 -> no valid pulse, dx all 0, busy=0; a following run completes normally with latency N+1.

Source files
------------

// File: rtl/tanh_backward_seq.sv
// Backward pass of an elementwise tanh over a HID_DIM x HID_DIM matrix.
// Each cycle one element computes dx = sat(dy * (1 - y*y)); y is held in a persistent store.
module tanh_backward_seq #(
   parameter int HID_DIM = 24,
   parameter int N_LEN   = 16,
   parameter int N_LEN_W = 16,
   parameter int F_LEN   = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load,
   input  logic [HID_DIM*HID_DIM*N_LEN_W-1:0]  y_in,
   input  logic                                run,
   input  logic [HID_DIM*HID_DIM*N_LEN-1:0]    dy,
   output logic                                busy,
   output logic                                valid,
   output logic [HID_DIM*HID_DIM*N_LEN-1:0]    dx
);

   localparam int N     = HID_DIM * HID_DIM;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int YB_W  = $clog2(N * N_LEN_W);
   localparam int GB_W  = $clog2(N * N_LEN);
   localparam int SQ_W  = 2 * N_LEN_W;
   localparam int S_W   = 2 * N_LEN_W + 1;
   localparam int PR_W  = N_LEN + S_W;

   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N - 1);
   localparam logic signed [S_W-1:0]  ONE      = S_W'(64'sd1 <<< F_LEN);
   localparam logic signed [PR_W-1:0] SAT_MAX  = PR_W'((64'sd1 <<< (N_LEN - 1)) - 64'sd1);
   localparam logic signed [PR_W-1:0] SAT_MIN  = PR_W'(-(64'sd1 <<< (N_LEN - 1)));

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   state_t                    r_state;
   state_t                    w_next_state;
   logic [IDX_W-1:0]          r_idx;
   logic [N*N_LEN_W-1:0]      r_y;
   logic [N*N_LEN-1:0]        r_dy;
   logic [N*N_LEN-1:0]        r_dx;
   logic                      r_busy;
   logic                      r_valid;

   logic [YB_W-1:0]           w_ybase;
   logic [GB_W-1:0]           w_gbase;
   logic signed [N_LEN_W-1:0] w_y;
   logic signed [N_LEN-1:0]   w_g;
   logic signed [SQ_W-1:0]    w_sq;
   logic signed [SQ_W-1:0]    w_p;
   logic signed [S_W-1:0]     w_s;
   logic signed [PR_W-1:0]    w_r;
   logic signed [PR_W-1:0]    w_rs;
   logic [N_LEN-1:0]          w_dx_elem;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (run) w_next_state = COMPUTE;
         COMPUTE: if (r_idx == LAST_IDX) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Element datapath: full-width products, floor shifts, saturation only at the end
   assign w_ybase = YB_W'(r_idx) * YB_W'(N_LEN_W);
   assign w_gbase = GB_W'(r_idx) * GB_W'(N_LEN);
   assign w_y     = r_y[w_ybase +: N_LEN_W];
   assign w_g     = r_dy[w_gbase +: N_LEN];
   assign w_sq    = SQ_W'(w_y) * SQ_W'(w_y);
   assign w_p     = w_sq >>> F_LEN;
   assign w_s     = ONE - S_W'(w_p);
   assign w_r     = PR_W'(w_g) * PR_W'(w_s);
   assign w_rs    = w_r >>> F_LEN;

   always_comb begin
      w_dx_elem = w_rs[N_LEN-1:0];
      if (w_rs > SAT_MAX) begin
         w_dx_elem = SAT_MAX[N_LEN-1:0];
      end else if (w_rs < SAT_MIN) begin
         w_dx_elem = SAT_MIN[N_LEN-1:0];
      end
   end

   // busy/valid are registered from the current state, so they trail the FSM by one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_y     <= '0;
         r_dy    <= '0;
         r_dx    <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_busy  <= (r_state != IDLE);
         r_valid <= (r_state == DONE);
         case (r_state)
            IDLE: begin
               if (load) r_y <= y_in;
               if (run) begin
                  r_dy  <= dy;
                  r_idx <= '0;
               end
            end
            COMPUTE: begin
               r_dx[w_gbase +: N_LEN] <= w_dx_elem;
               r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy  = r_busy;
   assign valid = r_valid;
   assign dx    = r_dx;

endmodule
